// File: rtl/pc_ir_stage_pkg.sv
// Shared definitions for the PC/IR fetch stage: next-PC select encodings,
// default widths and the instruction field bit positions.
package pc_ir_stage_pkg;

  localparam int unsigned DwlDefault = 32;
  localparam int unsigned AwlDefault = 6;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RSV = 2'b11
  } pc_sel_e;

  localparam int unsigned OpcHi   = 31;
  localparam int unsigned OpcLo   = 26;
  localparam int unsigned RsHi    = 25;
  localparam int unsigned RsLo    = 21;
  localparam int unsigned RtHi    = 20;
  localparam int unsigned RtLo    = 16;
  localparam int unsigned RdHi    = 15;
  localparam int unsigned RdLo    = 11;
  localparam int unsigned ImmHi   = 15;
  localparam int unsigned ImmLo   = 0;
  localparam int unsigned FunctHi = 5;
  localparam int unsigned FunctLo = 0;
  localparam int unsigned JIdxHi  = 25;
  localparam int unsigned JIdxLo  = 0;
  localparam int unsigned PcRgHi  = 31;
  localparam int unsigned PcRgLo  = 28;

endpackage

// File: rtl/pc_ir_stage_if.sv
// Control/data bundle between the control path and the PC/IR fetch stage.
interface pc_ir_stage_if #(
  parameter int unsigned DWL = 32,
  parameter int unsigned AWL = 6
);
  logic           pc_we;
  logic           branch;
  logic           zero;
  logic [AWL-5:0] pc_sel;
  logic           ir_we;
  logic [DWL-1:0] mem_rd;
  logic [DWL-1:0] alu_result;
  logic [DWL-1:0] alu_out;

  logic [DWL-1:0] pc;
  logic [DWL-1:0] instr;
  logic [DWL-1:0] mdr;
  logic [AWL-1:0] opcode;
  logic [AWL-1:0] funct;
  logic [4:0]     rs;
  logic [4:0]     rt;
  logic [4:0]     rd;
  logic [15:0]    imm;
  logic           pc_en;
  logic [31:0]    instr_count;
  logic [31:0]    cycle_count;
  logic           pc_sel_err;
  logic           misalign;

  modport master (
    output pc_we, branch, zero, pc_sel, ir_we, mem_rd, alu_result, alu_out,
    input  pc, instr, mdr, opcode, funct, rs, rt, rd, imm, pc_en,
           instr_count, cycle_count, pc_sel_err, misalign
  );

  modport slave (
    input  pc_we, branch, zero, pc_sel, ir_we, mem_rd, alu_result, alu_out,
    output pc, instr, mdr, opcode, funct, rs, rt, rd, imm, pc_en,
           instr_count, cycle_count, pc_sel_err, misalign
  );
endinterface

// File: rtl/en_reg.sv
// Width-parameterised register with enable, synchronous active-low reset
// and a configurable reset value.
module en_reg #(
  parameter int unsigned         Width    = 32,
  parameter logic [Width-1:0]    ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_o <= ResetVal;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pc_ir_stage.sv
// Fetch stage of a multicycle MIPS-style core: PC, instruction register,
// memory data register, decode slices, counters and sticky error flags.
module pc_ir_stage
  import pc_ir_stage_pkg::*;
#(
  parameter int unsigned    DWL      = DwlDefault,
  parameter int unsigned    AWL      = AwlDefault,
  parameter logic [DWL-1:0] RESET_PC = '0
) (
  input logic          clk_i,
  input logic          rst_ni,
  pc_ir_stage_if.slave bus
);

  logic [DWL-1:0] pc_q, instr_q, pc_next, mdr_q;
  logic [31:0]    instr_count_q, cycle_count_q;
  logic           pc_sel_err_q, pc_sel_err_d, misalign_q, misalign_d;
  logic           pc_en;
  pc_sel_e        sel;

  assign sel   = pc_sel_e'(bus.pc_sel);
  assign pc_en = bus.pc_we | (bus.branch & bus.zero);

  // Jump target is built from the old PC and old Instr, even when IR loads this edge.
  always_comb begin
    pc_next = pc_q;
    unique case (sel)
      PC_INC:  pc_next = bus.alu_result;
      PC_BR:   pc_next = bus.alu_out;
      PC_JMP:  pc_next = DWL'({pc_q[PcRgHi:PcRgLo], instr_q[JIdxHi:JIdxLo], 2'b00});
      PC_RSV:  pc_next = pc_q;
      default: pc_next = pc_q;
    endcase
  end

  always_comb begin
    pc_sel_err_d = pc_sel_err_q | (pc_en & (sel == PC_RSV));
    misalign_d   = misalign_q | (pc_en & (sel != PC_RSV) & (|pc_next[1:0]));
  end

  en_reg #(
    .Width    (DWL),
    .ResetVal (RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pc_en),
    .d_i    (pc_next),
    .q_o    (pc_q)
  );

  en_reg #(
    .Width    (DWL),
    .ResetVal ('0)
  ) u_ir_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (bus.ir_we),
    .d_i    (bus.mem_rd),
    .q_o    (instr_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mdr_q         <= '0;
      instr_count_q <= '0;
      cycle_count_q <= '0;
      pc_sel_err_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      mdr_q         <= bus.mem_rd;
      instr_count_q <= instr_count_q + 32'(bus.ir_we);
      cycle_count_q <= cycle_count_q + 32'd1;
      pc_sel_err_q  <= pc_sel_err_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.mdr         = mdr_q;
  assign bus.opcode      = AWL'(instr_q[OpcHi:OpcLo]);
  assign bus.funct       = AWL'(instr_q[FunctHi:FunctLo]);
  assign bus.rs          = instr_q[RsHi:RsLo];
  assign bus.rt          = instr_q[RtHi:RtLo];
  assign bus.rd          = instr_q[RdHi:RdLo];
  assign bus.imm         = instr_q[ImmHi:ImmLo];
  assign bus.pc_en       = pc_en;
  assign bus.instr_count = instr_count_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.pc_sel_err  = pc_sel_err_q;
  assign bus.misalign    = misalign_q;

endmodule
